// File: rtl/coin_key_debounce_pkg.sv
// Shared constants for the coin-key debounce front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coin_key_debounce_pkg;

    localparam int CLK_FREQ       = 50_000_000;
    localparam int DEBOUNCE_MS    = 20;
    localparam int DEB_CYCLES_DEF = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W_DEF      = 20;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_WAIT = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] REL_WAIT   = 2'd3;

    // The debounced level is high in both states that follow an accepted press.
    function automatic logic is_held(input logic [1:0] st);
        return (st == HELD) || (st == REL_WAIT);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, press/release debounce FSM and counter.
// Latency: strobe high in the cycle after edge E0+DEB_CYCLES+2 (E0 = first pin-low sample).
// Backpressure: none; strobe is a fire-and-forget single-cycle pulse.
module key_debounce_ch
    import coin_key_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic strobe,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             strobe_nxt;

    assign s = sync_q[1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        strobe_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt  = HELD;
                    cnt_nxt    = '0;
                    strobe_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (s) begin
                    state_nxt = REL_WAIT;
                    cnt_nxt   = '0;
                end
            end
            REL_WAIT: begin
                // A return to low here is release bounce, not a new coin.
                if (!s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            state  <= IDLE;
            cnt    <= '0;
            strobe <= 1'b0;
            held   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            strobe <= strobe_nxt;
            held   <= is_held(state_nxt);
        end
    end

endmodule

// File: rtl/coin_key_debounce.sv
// Coin-button front end: two debounced channels plus a key1-priority output arbiter.
// Latency: key1/key2 high in the cycle after edge E0+DEB_CYCLES+3; a colliding key2 slips one cycle.
// Backpressure: none; a losing strobe waits in a depth-1 pending flag.
module coin_key_debounce
    import coin_key_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key1_n,
    input  logic       key2_n,
    output logic       key1,
    output logic       key2,
    output logic [1:0] key_held
);

    logic strobe1;
    logic strobe2;
    logic held1;
    logic held2;
    logic pend1;
    logic pend2;
    logic req1;
    logic req2;
    logic grant1;
    logic grant2;

    key_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key1_n),
        .strobe (strobe1),
        .held   (held1)
    );

    key_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key2_n),
        .strobe (strobe2),
        .held   (held2)
    );

    assign key_held = {held2, held1};

    // key1 always wins; strobes on one channel are far apart so one pending slot suffices.
    assign req1   = strobe1 | pend1;
    assign req2   = strobe2 | pend2;
    assign grant1 = req1;
    assign grant2 = req2 & ~req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key1  <= 1'b0;
            key2  <= 1'b0;
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            key1  <= grant1;
            key2  <= grant2;
            pend1 <= req1 & ~grant1;
            pend2 <= req2 & ~grant2;
        end
    end

endmodule

// File: tb/tb_coin_key_debounce.sv
// Directed bench for coin_key_debounce with DEB_CYCLES=8: pulse timing, bounce, collisions, reset.
module tb_coin_key_debounce;

    logic       clk;
    logic       rst_n;
    logic       key1_n;
    logic       key2_n;
    logic       key1;
    logic       key2;
    logic [1:0] key_held;

    int errors = 0;
    int checks = 0;

    coin_key_debounce #(.DEB_CYCLES(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key1_n   (key1_n),
        .key2_n   (key2_n),
        .key1     (key1),
        .key2     (key2),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples n falling edges; index i counts falling edges after the last drive.
    task automatic observe(input int n, output int c1, output int i1, output int c2,
                           output int i2, output int both, output int h0_all, output int h0_first);
        c1 = 0; i1 = 0; c2 = 0; i2 = 0; both = 0; h0_all = 1; h0_first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (key1 === 1'b1) begin c1++; if (i1 == 0) i1 = i; end
            if (key2 === 1'b1) begin c2++; if (i2 == 0) i2 = i; end
            if (key1 === 1'b1 && key2 === 1'b1) both++;
            if (key_held[0] !== 1'b1) h0_all = 0;
            if (key_held[0] === 1'b1 && h0_first == 0) h0_first = i;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; key1_n = 1'b1; key2_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({key1, key2, key_held} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b want 0000", {key1, key2, key_held});
            end
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({key1, key2, key_held} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 0000", {key1, key2, key_held});
        end
    endtask

    task automatic test_clean_press;
        int c1, i1, c2, i2, both, h0a, h0f;
        key1_n = 1'b0;
        observe(40, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (c1 !== 1)   begin errors++; $display("FAIL clean_key1_count: got %0d want 1", c1); end
        checks++; if (i1 !== 12)  begin errors++; $display("FAIL clean_key1_time: got %0d want 12", i1); end
        checks++; if (c2 !== 0)   begin errors++; $display("FAIL clean_key2_quiet: got %0d want 0", c2); end
        checks++; if (h0f !== 11) begin errors++; $display("FAIL clean_held_time: got %0d want 11", h0f); end
        checks++; if (key_held !== 2'b01) begin errors++; $display("FAIL clean_held_level: got %b want 01", key_held); end
        key1_n = 1'b1;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (key_held !== 2'b00) begin errors++; $display("FAIL clean_release_level: got %b want 00", key_held); end
        checks++; if (c1 + c2 !== 0) begin errors++; $display("FAIL clean_release_pulse: got %0d want 0", c1 + c2); end
    endtask

    task automatic test_bounce;
        int c1, i1, c2, i2, both, h0a, h0f;
        int bounce_pulses = 0;
        for (int c = 0; c < 30; c++) begin
            key2_n = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            observe(1, c1, i1, c2, i2, both, h0a, h0f);
            bounce_pulses += c1 + c2;
        end
        checks++; if (bounce_pulses !== 0) begin errors++; $display("FAIL bounce_rejected: got %0d want 0", bounce_pulses); end
        key2_n = 1'b0;
        observe(40, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (c2 !== 1)  begin errors++; $display("FAIL bounce_key2_count: got %0d want 1", c2); end
        checks++; if (i2 !== 12) begin errors++; $display("FAIL bounce_key2_time: got %0d want 12", i2); end
        checks++; if (c1 !== 0)  begin errors++; $display("FAIL bounce_key1_quiet: got %0d want 0", c1); end
        checks++; if (key_held !== 2'b10) begin errors++; $display("FAIL bounce_held_level: got %b want 10", key_held); end
        key2_n = 1'b1;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
    endtask

    task automatic test_simultaneous;
        int c1, i1, c2, i2, both, h0a, h0f;
        key1_n = 1'b0; key2_n = 1'b0;
        observe(40, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (i1 !== 12)  begin errors++; $display("FAIL simul_key1_time: got %0d want 12", i1); end
        checks++; if (i2 !== 13)  begin errors++; $display("FAIL simul_key2_time: got %0d want 13", i2); end
        checks++; if (both !== 0) begin errors++; $display("FAIL simul_never_both: got %0d want 0", both); end
        checks++; if (c1 !== 1 || c2 !== 1) begin errors++; $display("FAIL simul_counts: got %0d/%0d want 1/1", c1, c2); end
        checks++; if (key_held !== 2'b11) begin errors++; $display("FAIL simul_held_level: got %b want 11", key_held); end
        key1_n = 1'b1; key2_n = 1'b1;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
    endtask

    task automatic test_release_glitch;
        int c1, i1, c2, i2, both, h0a, h0f;
        int pulses = 0;
        key1_n = 1'b0;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (c1 !== 1) begin errors++; $display("FAIL glitch_first_pulse: got %0d want 1", c1); end
        key1_n = 1'b1;
        observe(4, c1, i1, c2, i2, both, h0a, h0f);
        pulses += c1;
        checks++; if (h0a !== 1) begin errors++; $display("FAIL glitch_held_during: got %0d want 1", h0a); end
        key1_n = 1'b0;
        observe(30, c1, i1, c2, i2, both, h0a, h0f);
        pulses += c1;
        checks++; if (h0a !== 1)    begin errors++; $display("FAIL glitch_held_after: got %0d want 1", h0a); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_no_pulse: got %0d want 0", pulses); end
    endtask

    task automatic test_repress;
        int c1, i1, c2, i2, both, h0a, h0f;
        key1_n = 1'b1;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (key_held[0] !== 1'b0) begin errors++; $display("FAIL repress_released: got %b want 0", key_held[0]); end
        key1_n = 1'b0;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (c1 !== 1)  begin errors++; $display("FAIL repress_pulse_count: got %0d want 1", c1); end
        checks++; if (i1 !== 12) begin errors++; $display("FAIL repress_pulse_time: got %0d want 12", i1); end
        key1_n = 1'b1;
        observe(20, c1, i1, c2, i2, both, h0a, h0f);
    endtask

    task automatic test_reset_mid_press;
        int c1, i1, c2, i2, both, h0a, h0f;
        key1_n = 1'b0;
        observe(5, c1, i1, c2, i2, both, h0a, h0f);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({key1, key2, key_held} !== 4'b0000) begin
                errors++;
                $display("FAIL midreset_outputs: got %b want 0000", {key1, key2, key_held});
            end
        end
        rst_n = 1'b1;
        observe(40, c1, i1, c2, i2, both, h0a, h0f);
        checks++; if (c1 !== 1)  begin errors++; $display("FAIL midreset_pulse_count: got %0d want 1", c1); end
        checks++; if (i1 !== 12) begin errors++; $display("FAIL midreset_pulse_time: got %0d want 12", i1); end
        checks++; if (c2 !== 0)  begin errors++; $display("FAIL midreset_key2_quiet: got %0d want 0", c2); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_glitch();
        test_repress();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
